// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared definitions for the NoC tree router blocks.
//   - WIDTH_packet / ADDR_W : default packet and destination-address widths
//   - packet_t              : packet layout, address in the top ADDR_W bits
//   - in_state_t            : input handshake FSM states
//   - out_state_t           : per-child output handshake FSM states
package noc_pkg;

   localparam int unsigned WIDTH_packet = 14;
   localparam int unsigned ADDR_W       = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]              addr;
      logic [WIDTH_packet-ADDR_W-1:0] payload;
   } packet_t;

   typedef enum logic {
      IN_IDLE,
      IN_ACK
   } in_state_t;

   typedef enum logic [1:0] {
      O_IDLE,
      O_REQ,
      O_REL
   } out_state_t;

endpackage

// File: rtl/input_ctrl_fifo.sv
// input_ctrl_fifo
//   Circular-buffer FIFO for one child port of input_ctrl.
//   Pointers carry one extra wrap bit, so full/empty come from comparing it.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (clears contents)
//     push     : write din (ignored when full)
//     pop      : advance the head (ignored when empty)
//     din      : write data
//     dout     : current head entry
//     full     : DEPTH entries stored
//     empty    : no entries stored
module input_ctrl_fifo #(
   parameter int unsigned WIDTH_packet = 14,
   parameter int unsigned DEPTH        = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH_packet-1:0] din,
   output logic [WIDTH_packet-1:0] dout,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]             wptr;
   logic [AW:0]             rptr;
   logic [WIDTH_packet-1:0] mem [DEPTH];

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];

   // Storage is cleared on reset so the child data outputs read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop && !empty) begin
            rptr <= rptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/input_ctrl.sv
// input_ctrl
//   1-to-2 packet splitter for the NoC tree router. One 4-phase req/ack input
//   port; each packet is routed by address bit in_data[WIDTH_packet-1-LEVEL]
//   into one of two FIFOs, each drained by its own 4-phase child port.
//   Optional macro INPUT_CTRL_STATS_EN adds per-child delivery counters.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_req/in_ack       : upstream handshake
//     in_data             : upstream packet, stable while in_req=1
//     out0_req/out0_ack   : child 0 handshake (route bit 0)
//     out0_data           : child 0 packet (FIFO 0 head)
//     out1_req/out1_ack   : child 1 handshake (route bit 1)
//     out1_data           : child 1 packet (FIFO 1 head)
//     cnt0/cnt1           : packets delivered per child (stats build only)
module input_ctrl
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH_packet = 14,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned LEVEL        = 0,
   parameter int unsigned DEPTH        = 2
`ifdef INPUT_CTRL_STATS_EN
   ,
   parameter int unsigned CNT_W        = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_req,
   output logic                    in_ack,
   input  logic [WIDTH_packet-1:0] in_data,
   output logic                    out0_req,
   input  logic                    out0_ack,
   output logic [WIDTH_packet-1:0] out0_data,
   output logic                    out1_req,
   input  logic                    out1_ack,
   output logic [WIDTH_packet-1:0] out1_data
`ifdef INPUT_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0]        cnt0,
   output logic [CNT_W-1:0]        cnt1
`endif
);

   // Route bit: bit (ADDR_W-1-LEVEL) of the address field in the top ADDR_W bits.
   localparam int unsigned ROUTE_BIT = WIDTH_packet - ADDR_W + (ADDR_W - 1 - LEVEL);

   in_state_t               in_state;
   logic                    sel;
   logic [1:0]              push;
   logic [1:0]              pop;
   logic [1:0]              full;
   logic [1:0]              empty;
   logic [1:0]              o_req;
   logic [1:0]              o_ack;
   logic [WIDTH_packet-1:0] dout [2];

   assign sel   = in_data[ROUTE_BIT];
   assign o_ack = {out1_ack, out0_ack};

   // Write strobe uses start-of-cycle full, so a same-edge pop never admits it.
   assign push[0] = (in_state == IN_IDLE) && in_req && !sel && !full[0];
   assign push[1] = (in_state == IN_IDLE) && in_req &&  sel && !full[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         in_state <= IN_IDLE;
         in_ack   <= 1'b0;
      end else begin
         case (in_state)
            IN_IDLE: begin
               if (in_req && !full[sel]) begin
                  in_ack   <= 1'b1;
                  in_state <= IN_ACK;
               end
            end
            IN_ACK: begin
               if (!in_req) begin
                  in_ack   <= 1'b0;
                  in_state <= IN_IDLE;
               end
            end
            default: begin
               in_ack   <= 1'b0;
               in_state <= IN_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_child
      out_state_t o_state;

      input_ctrl_fifo #(
         .WIDTH_packet (WIDTH_packet),
         .DEPTH        (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (in_data),
         .dout  (dout[g]),
         .full  (full[g]),
         .empty (empty[g])
      );

      assign pop[g] = (o_state == O_REQ) && o_ack[g];

      always_ff @(posedge clk) begin
         if (rst) begin
            o_state  <= O_IDLE;
            o_req[g] <= 1'b0;
         end else begin
            case (o_state)
               O_IDLE: begin
                  if (!empty[g]) begin
                     o_req[g] <= 1'b1;
                     o_state  <= O_REQ;
                  end
               end
               O_REQ: begin
                  if (o_ack[g]) begin
                     o_req[g] <= 1'b0;
                     o_state  <= O_REL;
                  end
               end
               O_REL: begin
                  if (!o_ack[g]) begin
                     o_state <= O_IDLE;
                  end
               end
               default: begin
                  o_req[g] <= 1'b0;
                  o_state  <= O_IDLE;
               end
            endcase
         end
      end
   end

   assign out0_req  = o_req[0];
   assign out1_req  = o_req[1];
   assign out0_data = dout[0];
   assign out1_data = dout[1];

`ifdef INPUT_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (pop[0]) cnt0 <= cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
         if (pop[1]) cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`endif

endmodule

// File: tb/tb_input_ctrl.sv
// tb_input_ctrl
//   Directed bench for input_ctrl: a LEVEL=0 instance exercises routing,
//   backpressure, head-of-line blocking, reset and (stats build) counters;
//   a LEVEL=1 instance with auto-acking children checks the level decode.
module tb_input_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_req, in_ack;
   logic [13:0] in_data;
   logic        out0_req, out0_ack, out1_req, out1_ack;
   logic [13:0] out0_data, out1_data;
`ifdef INPUT_CTRL_STATS_EN
   logic [2:0]  cnt0, cnt1;
`endif

   logic        b_in_req, b_in_ack;
   logic [13:0] b_in_data;
   logic        b_out0_req, b_out0_ack, b_out1_req, b_out1_ack;
   logic [13:0] b_out0_data, b_out1_data;
`ifdef INPUT_CTRL_STATS_EN
   logic [2:0]  b_cnt0, b_cnt1;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   input_ctrl #(
      .WIDTH_packet (14),
      .ADDR_W       (4),
      .LEVEL        (0),
      .DEPTH        (2)
`ifdef INPUT_CTRL_STATS_EN
      ,
      .CNT_W        (3)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_req    (in_req),
      .in_ack    (in_ack),
      .in_data   (in_data),
      .out0_req  (out0_req),
      .out0_ack  (out0_ack),
      .out0_data (out0_data),
      .out1_req  (out1_req),
      .out1_ack  (out1_ack),
      .out1_data (out1_data)
`ifdef INPUT_CTRL_STATS_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1)
`endif
   );

   // Children of the LEVEL=1 instance acknowledge immediately.
   assign b_out0_ack = b_out0_req;
   assign b_out1_ack = b_out1_req;

   input_ctrl #(
      .WIDTH_packet (14),
      .ADDR_W       (4),
      .LEVEL        (1),
      .DEPTH        (2)
`ifdef INPUT_CTRL_STATS_EN
      ,
      .CNT_W        (3)
`endif
   ) dut_l1 (
      .clk       (clk),
      .rst       (rst),
      .in_req    (b_in_req),
      .in_ack    (b_in_ack),
      .in_data   (b_in_data),
      .out0_req  (b_out0_req),
      .out0_ack  (b_out0_ack),
      .out0_data (b_out0_data),
      .out1_req  (b_out1_req),
      .out1_ack  (b_out1_ack),
      .out1_data (b_out1_data)
`ifdef INPUT_CTRL_STATS_EN
      ,
      .cnt0      (b_cnt0),
      .cnt1      (b_cnt1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic req_of(input bit ch);
      return ch ? out1_req : out0_req;
   endfunction

   function automatic logic [13:0] data_of(input bit ch);
      return ch ? out1_data : out0_data;
   endfunction

   task automatic set_ack(input bit ch, input logic v);
      if (ch) out1_ack = v;
      else    out0_ack = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Full 4-phase upstream transfer, bounded waits.
   task automatic send(input logic [13:0] d, input string tag);
      int unsigned n;
      in_data = d;
      in_req  = 1'b1;
      n = 0;
      while (!in_ack && n < 40) begin tick(); n++; end
      check({tag, "_ack"}, in_ack, 1);
      in_req = 1'b0;
      n = 0;
      while (in_ack && n < 40) begin tick(); n++; end
      check({tag, "_ackrel"}, in_ack, 0);
   endtask

   // Full 4-phase child transfer with data check, bounded waits.
   task automatic recv(input bit ch, input logic [13:0] exp, input string tag);
      int unsigned n;
      n = 0;
      while (!req_of(ch) && n < 40) begin tick(); n++; end
      check({tag, "_req"}, req_of(ch), 1);
      check({tag, "_data"}, data_of(ch), exp);
      set_ack(ch, 1'b1);
      n = 0;
      while (req_of(ch) && n < 40) begin tick(); n++; end
      check({tag, "_reqrel"}, req_of(ch), 0);
      set_ack(ch, 1'b0);
      tick();
   endtask

   // LEVEL=1 instance: send one packet, observe which child delivers it.
   task automatic route_l1(input logic [13:0] d, input bit exp_ch, input string tag);
      int unsigned n;
      logic got0, got1;
      logic [13:0] gd;
      got0 = 1'b0;
      got1 = 1'b0;
      gd   = '0;
      b_in_data = d;
      b_in_req  = 1'b1;
      n = 0;
      while (!b_in_ack && n < 40) begin tick(); n++; end
      check({tag, "_ack"}, b_in_ack, 1);
      b_in_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b_out0_req) begin got0 = 1'b1; gd = b_out0_data; end
         if (b_out1_req) begin got1 = 1'b1; gd = b_out1_data; end
         tick();
      end
      check({tag, "_out1"}, got1, exp_ch);
      check({tag, "_out0"}, got0, !exp_ch);
      check({tag, "_data"}, gd, d);
   endtask

   localparam logic [13:0] P_A  = 14'b10100000100000;
   localparam logic [13:0] P_B  = 14'b01011111000000;
   localparam logic [13:0] P_L1 = 14'b01101010111110;
   localparam logic [13:0] P_L0 = 14'b10000100111110;

   initial begin
      rst       = 1'b1;
      in_req    = 1'b0;
      in_data   = '0;
      out0_ack  = 1'b0;
      out1_ack  = 1'b0;
      b_in_req  = 1'b0;
      b_in_data = '0;
      do_reset();

      // Reset state
      check("rst_in_ack", in_ack, 0);
      check("rst_out0_req", out0_req, 0);
      check("rst_out1_req", out1_req, 0);
      check("rst_out0_data", out0_data, 0);
      check("rst_out1_data", out1_data, 0);

      // LEVEL=0, sel=1 with exact latencies
      in_data = P_A;
      in_req  = 1'b1;
      tick();
      check("lat_in_ack", in_ack, 1);
      check("lat_out1_early", out1_req, 0);
      in_req = 1'b0;
      tick();
      check("lat_ack_drop", in_ack, 0);
      check("lat_out1_req", out1_req, 1);
      check("lat_out1_data", out1_data, P_A);
      check("lat_out0_quiet", out0_req, 0);
      out1_ack = 1'b1;
      tick();
      check("lat_out1_drop", out1_req, 0);
      out1_ack = 1'b0;
      tick();

      // LEVEL=0, sel=0
      send(P_B, "l0_b");
      check("l0_b_out0", out0_req, 1);
      check("l0_b_out1", out1_req, 0);
      recv(0, P_B, "l0_b_rx");

      // LEVEL=1 decode
      route_l1(P_L1, 1'b1, "l1_a");
      route_l1(P_L0, 1'b0, "l1_b");

      // Backpressure on full FIFO 1, no bypass on same-edge pop
      send(14'h2001, "bp1");
      send(14'h2002, "bp2");
      in_data = 14'h2003;
      in_req  = 1'b1;
      repeat (5) tick();
      check("bp_full_noack", in_ack, 0);
      check("bp_head", out1_data, 14'h2001);
      out1_ack = 1'b1;
      tick();
      check("bp_pop_req", out1_req, 0);
      check("bp_no_bypass", in_ack, 0);
      tick();
      check("bp_admit_next", in_ack, 1);
      in_req   = 1'b0;
      out1_ack = 1'b0;
      tick();
      recv(1, 14'h2002, "bp_rx2");
      recv(1, 14'h2003, "bp_rx3");

      // Simultaneous write and pop on FIFO 0 holding one entry
      send(14'h0101, "wp1");
      in_data  = 14'h0102;
      in_req   = 1'b1;
      out0_ack = 1'b1;
      tick();
      check("wp_ack", in_ack, 1);
      check("wp_pop", out0_req, 0);
      in_req   = 1'b0;
      out0_ack = 1'b0;
      tick();
      recv(0, 14'h0102, "wp_rx2");
      repeat (3) tick();
      check("wp_empty", out0_req, 0);

      // Head-of-line blocking behind a stalled sel=1 packet
      send(14'h3001, "hol1");
      send(14'h3002, "hol2");
      in_data = 14'h3003;
      in_req  = 1'b1;
      repeat (4) tick();
      check("hol_stall", in_ack, 0);
      check("hol_out0_idle", out0_req, 0);
      recv(1, 14'h3001, "hol_rx1");
      check("hol_admit", in_ack, 1);
      in_req = 1'b0;
      tick();
      send(14'h0404, "hol4");
      recv(0, 14'h0404, "hol_rx4");
      recv(1, 14'h3002, "hol_rx2");
      recv(1, 14'h3003, "hol_rx3");

      // Reset mid-handshake with one packet buffered
      send(14'h0555, "mr1");
      check("mr_req_up", out0_req, 1);
      rst = 1'b1;
      tick();
      check("mr_out0_req", out0_req, 0);
      check("mr_out0_data", out0_data, 0);
      check("mr_out1_req", out1_req, 0);
      check("mr_in_ack", in_ack, 0);
      rst = 1'b0;
      repeat (3) tick();
      check("mr_fifo_empty", out0_req, 0);
      send(14'h2666, "mr2");
      recv(1, 14'h2666, "mr_rx2");

`ifdef INPUT_CTRL_STATS_EN
      do_reset();
      check("st_rst_cnt0", cnt0, 0);
      check("st_rst_cnt1", cnt1, 0);
      for (int i = 0; i < 5; i++) begin
         send(14'h0010 + 14'(i), "st0");
         recv(0, 14'h0010 + 14'(i), "st0_rx");
      end
      for (int i = 0; i < 3; i++) begin
         send(14'h2020 + 14'(i), "st1");
         recv(1, 14'h2020 + 14'(i), "st1_rx");
      end
      check("st_cnt0", cnt0, 5);
      check("st_cnt1", cnt1, 3);
      for (int i = 0; i < 3; i++) begin
         send(14'h0030 + 14'(i), "stw");
         recv(0, 14'h0030 + 14'(i), "stw_rx");
      end
      check("st_cnt0_wrap", cnt0, 0);
      check("st_cnt1_hold", cnt1, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
